// File: rtl/fractal_stream_video_out_if.sv
// Pixel stream bundle between the fractal source and the video sink.
//   tvalid  beat valid (master -> slave)
//   tready  sink can take the beat (slave -> master)
//   tdata   pixel
//   tuser   first pixel of a frame
//   tlast   last pixel of a line
interface fractal_stream_video_out_if #(
   parameter int DATA_WIDTH = 24
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tuser;
   logic                  tlast;

   modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/fractal_stream_video_out.sv
// Video sink for the fractal pixel stream. Beats are buffered in a
// first-word-fall-through FIFO and replayed under a free-running raster
// timing generator as native video.
//
// Ports
//   aclk, aresetn      clock, async active-low reset
//   s_axis             stream slave (tvalid/tready/tdata/tuser=SOF/tlast=EOL)
//   err_clear          one-cycle pulse clearing the sticky error flags
//   vid_data           pixel, 0 outside active video or when not locked
//   vid_active_video   data enable
//   vid_hsync/vsync    active-high syncs
//   locked             FSM in LOCKED
//   err_underflow      sticky: FIFO empty on an active pixel while locked
//   err_desync         sticky: popped tuser/tlast disagree with raster position
//
// state   | meaning
// SEARCH  | discard beats until a start-of-frame beat, which is kept
// ARMED   | fill FIFO, lock at frame wrap once level >= PREFILL
// LOCKED  | pop one entry per active pixel and check its framing
module fractal_stream_video_out #(
   parameter int DATA_WIDTH = 24,
   parameter int H_ACTIVE   = 1920,
   parameter int H_FP       = 88,
   parameter int H_SYNC     = 44,
   parameter int H_BP       = 148,
   parameter int V_ACTIVE   = 1080,
   parameter int V_FP       = 4,
   parameter int V_SYNC     = 5,
   parameter int V_BP       = 36,
   parameter int FIFO_DEPTH = 4096,
   parameter int PREFILL    = 2048
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   fractal_stream_video_out_if.slave       s_axis,
   input  logic                            err_clear,
   output logic [DATA_WIDTH-1:0]           vid_data,
   output logic                            vid_active_video,
   output logic                            vid_hsync,
   output logic                            vid_vsync,
   output logic                            locked,
   output logic                            err_underflow,
   output logic                            err_desync
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = DATA_WIDTH + 2;

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_ARMED,
      ST_LOCKED
   } state_t;

   state_t state, state_nxt;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_last, v_last, frame_end;
   logic          active, hsync_c, vsync_c;

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic          fifo_full, fifo_empty;
   logic [EW-1:0] rd_entry;
   logic          rd_user, rd_last;
   logic [DATA_WIDTH-1:0] rd_data;

   logic          run;
   logic          accept;
   logic          wr_en, rd_en, flush;
   logic          set_uf, set_ds;
   logic          exp_user, exp_last;
   logic [DATA_WIDTH-1:0] pix_out;

   // Raster timing
   assign h_last    = (int'(h_cnt) == H_TOTAL - 1);
   assign v_last    = (int'(v_cnt) == V_TOTAL - 1);
   assign frame_end = h_last && v_last;
   assign active    = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
   assign hsync_c   = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
   assign vsync_c   = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
   assign exp_user  = (h_cnt == '0) && (v_cnt == '0);
   assign exp_last  = (int'(h_cnt) == H_ACTIVE - 1);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   // FIFO status and head entry
   assign fifo_full  = (level == LW'(FIFO_DEPTH));
   assign fifo_empty = (level == '0);
   assign rd_entry   = mem[rd_ptr];
   assign {rd_user, rd_last, rd_data} = rd_entry;

   // run keeps tready low while in reset so every output is 0 there
   assign s_axis.tready = run && ((state == ST_SEARCH) || !fifo_full);
   assign accept        = s_axis.tvalid && s_axis.tready;
   assign locked        = (state == ST_LOCKED);

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      flush     = 1'b0;
      set_uf    = 1'b0;
      set_ds    = 1'b0;
      pix_out   = '0;
      case (state)
         ST_SEARCH: begin
            if (accept && s_axis.tuser) begin
               wr_en     = 1'b1;
               state_nxt = ST_ARMED;
            end
         end
         ST_ARMED: begin
            wr_en = accept;
            if (frame_end && (int'(level) >= PREFILL))
               state_nxt = ST_LOCKED;
         end
         ST_LOCKED: begin
            wr_en = accept;
            if (active) begin
               // A write landing in an empty FIFO this cycle is too late to display.
               if (fifo_empty) begin
                  set_uf    = 1'b1;
                  flush     = 1'b1;
                  wr_en     = 1'b0;
                  state_nxt = ST_SEARCH;
               end else if ((rd_user != exp_user) || (rd_last != exp_last)) begin
                  set_ds    = 1'b1;
                  flush     = 1'b1;
                  wr_en     = 1'b0;
                  state_nxt = ST_SEARCH;
               end else begin
                  rd_en   = 1'b1;
                  pix_out = rd_data;
               end
            end
         end
         default: state_nxt = ST_SEARCH;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state  <= ST_SEARCH;
         run    <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         state <= state_nxt;
         run   <= 1'b1;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(wr_en) - LW'(rd_en);
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_ptr] <= {s_axis.tuser, s_axis.tlast, s_axis.tdata};
   end

   // Registered video outputs and sticky errors; an error event beats err_clear.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         vid_data         <= '0;
         vid_active_video <= 1'b0;
         vid_hsync        <= 1'b0;
         vid_vsync        <= 1'b0;
         err_underflow    <= 1'b0;
         err_desync       <= 1'b0;
      end else begin
         vid_data         <= pix_out;
         vid_active_video <= active;
         vid_hsync        <= hsync_c;
         vid_vsync        <= vsync_c;
         if (set_uf)         err_underflow <= 1'b1;
         else if (err_clear) err_underflow <= 1'b0;
         if (set_ds)         err_desync <= 1'b1;
         else if (err_clear) err_desync <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fractal_stream_video_out.sv
module tb_fractal_stream_video_out;
   localparam int DW = 24;
   localparam int HT = 14;
   localparam int VT = 7;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          err_clear = 1'b0;
   logic [DW-1:0] vid_data;
   logic          vid_active_video, vid_hsync, vid_vsync;
   logic          locked, err_underflow, err_desync;

   fractal_stream_video_out_if #(.DATA_WIDTH(DW)) s_axis ();

   fractal_stream_video_out #(
      .DATA_WIDTH(DW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .FIFO_DEPTH(64), .PREFILL(16)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .s_axis(s_axis), .err_clear(err_clear),
      .vid_data(vid_data), .vid_active_video(vid_active_video),
      .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .locked(locked),
      .err_underflow(err_underflow), .err_desync(err_desync)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [DW-1:0] data;
      logic          user;
      logic          last;
   } beat_t;

   beat_t         src_q[$];
   logic [DW-1:0] exp_q[$];
   int            n_chk = 0;
   int            n_bad = 0;
   int            pix;
   int            seq = 0;
   bit            src_on;
   bit            acc_prev;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s pix=%0d got=%0h want=%0h", tag, pix, obs, exp);
      end
   endtask

   task automatic src_drive();
      if (acc_prev && src_q.size() > 0) void'(src_q.pop_front());
      if (src_on && src_q.size() > 0) begin
         s_axis.tvalid = 1'b1;
         s_axis.tdata  = src_q[0].data;
         s_axis.tuser  = src_q[0].user;
         s_axis.tlast  = src_q[0].last;
      end else begin
         s_axis.tvalid = 1'b0;
      end
      acc_prev = s_axis.tvalid && s_axis.tready;
   endtask

   task automatic tick();
      @(posedge aclk);
      @(negedge aclk);
      pix++;
      src_drive();
   endtask

   task automatic push_frame(input bit bad);
      beat_t b;
      for (int i = 0; i < 32; i++) begin
         b.data = 24'h100000 + DW'(seq);
         seq++;
         b.user = (i == 0);
         b.last = (i % 8 == 7);
         if (bad && i == 6) b.last = 1'b1;
         if (bad && i == 7) b.last = 1'b0;
         src_q.push_back(b);
         exp_q.push_back(b.data);
      end
   endtask

   task automatic push_garbage(input int n);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.data = 24'hDEAD00 + DW'(i);
         b.user = 1'b0;
         b.last = (i == 2);
         src_q.push_back(b);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data"},   32'(vid_data), 0);
      chk({tag, "_de"},     32'(vid_active_video), 0);
      chk({tag, "_hs"},     32'(vid_hsync), 0);
      chk({tag, "_vs"},     32'(vid_vsync), 0);
      chk({tag, "_locked"}, 32'(locked), 0);
      chk({tag, "_uf"},     32'(err_underflow), 0);
      chk({tag, "_ds"},     32'(err_desync), 0);
      chk({tag, "_ready"},  32'(s_axis.tready), 0);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      src_on = 1'b0;
      src_q.delete();
      exp_q.delete();
      acc_prev = 1'b0;
      s_axis.tvalid = 1'b0;
      s_axis.tdata = '0;
      s_axis.tuser = 1'b0;
      s_axis.tlast = 1'b0;
      err_clear = 1'b0;
      repeat (3) @(negedge aclk);
      chk_all_zero("rst");
      aresetn = 1'b1;
      pix = -1;
   endtask

   function automatic bit m_active(input int p);
      return ((p % HT) < 8) && (((p / HT) % VT) < 4);
   endfunction

   task automatic chk_disp();
      logic [31:0] e;
      if (m_active(pix)) begin
         e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
         chk("disp", 32'(vid_data), e);
      end
   endtask

   initial begin
      // 1: idle raster
      do_reset();
      src_drive();
      while (pix < 97) begin
         tick();
         chk("t1_de", 32'(vid_active_video), 32'(m_active(pix)));
         chk("t1_hs", 32'(vid_hsync), 32'(((pix % HT) >= 10) && ((pix % HT) < 12)));
         chk("t1_vs", 32'(vid_vsync), 32'(((pix / HT) % VT) == 5));
         chk("t1_data", 32'(vid_data), 0);
         chk("t1_locked", 32'(locked), 0);
      end

      // 2: continuous frames, backpressure, then async reset mid-line
      do_reset();
      for (int f = 0; f < 4; f++) push_frame(1'b0);
      src_on = 1'b1;
      src_drive();
      while (pix < 200) begin
         tick();
         if (pix == 96) chk("t2_lock_pre", 32'(locked), 0);
         if (pix == 97) chk("t2_lock", 32'(locked), 1);
         if (pix >= 98) chk_disp();
         if (pix == 170) chk("t2_full_ready", 32'(s_axis.tready), 0);
      end
      chk("t2_de_mid", 32'(vid_active_video), 1);
      chk("t2_uf", 32'(err_underflow), 0);
      chk("t2_ds", 32'(err_desync), 0);
      #2 aresetn = 1'b0;
      #1 chk_all_zero("t2_async");

      // 3/4: garbage discarded, lock, source runs dry -> underflow, relock
      do_reset();
      push_garbage(5);
      push_frame(1'b0);
      push_frame(1'b0);
      src_on = 1'b1;
      src_drive();
      while (pix < 585) begin
         tick();
         if (pix <= 4) chk("t3_garbage_ready", 32'(s_axis.tready), 1);
         if (pix == 96) chk("t3_lock_pre", 32'(locked), 0);
         if (pix == 97) chk("t3_lock", 32'(locked), 1);
         if (pix >= 98 && pix <= 293) chk_disp();
         if (pix == 293) begin
            chk("t4_lock_pre_uf", 32'(locked), 1);
            chk("t4_uf_pre", 32'(err_underflow), 0);
            err_clear = 1'b1;
         end
         if (pix == 294) begin
            err_clear = 1'b0;
            chk("t4_uf_data", 32'(vid_data), 0);
            chk("t4_uf_wins_clear", 32'(err_underflow), 1);
            chk("t4_uf_unlock", 32'(locked), 0);
         end
         if (pix == 300) begin
            push_frame(1'b0);
            push_frame(1'b0);
         end
         if (pix == 390) chk("t4_relock_pre", 32'(locked), 0);
         if (pix == 391) chk("t4_relock", 32'(locked), 1);
         if (pix >= 392) chk_disp();
      end
      chk("t4_uf_sticky", 32'(err_underflow), 1);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("t4_uf_cleared", 32'(err_underflow), 0);

      // 5: early tlast -> desync, flush, clear, relock on fresh frame
      do_reset();
      push_frame(1'b0);
      push_frame(1'b1);
      src_on = 1'b1;
      src_drive();
      while (pix < 391) begin
         tick();
         if (pix == 97) chk("t5_lock", 32'(locked), 1);
         if (pix >= 98 && pix <= 201) chk_disp();
         if (pix == 201) chk("t5_ds_pre", 32'(err_desync), 0);
         if (pix == 202) begin
            chk("t5_ds_data", 32'(vid_data), 0);
            chk("t5_ds", 32'(err_desync), 1);
            chk("t5_ds_unlock", 32'(locked), 0);
            chk("t5_search_ready", 32'(s_axis.tready), 1);
            exp_q.delete();
         end
         if (pix == 210) begin
            chk("t5_ds_sticky", 32'(err_desync), 1);
            err_clear = 1'b1;
         end
         if (pix == 211) begin
            err_clear = 1'b0;
            chk("t5_ds_cleared", 32'(err_desync), 0);
            chk("t5_uf_clean", 32'(err_underflow), 0);
         end
         if (pix == 220) push_frame(1'b0);
         if (pix == 292) chk("t5_relock_pre", 32'(locked), 0);
         if (pix == 293) chk("t5_relock", 32'(locked), 1);
         if (pix >= 294) chk_disp();
      end
      chk("t5_no_err", 32'(err_desync), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
